// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core (C) and loader (L) request groups.
// Round-robin grant, IDLE/ACCESS/WAIT/RESP sequencing, registered read data and ack pulses.
module dmem_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic          clk,
    input  logic          areset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic          c_err,
    output logic [DW-1:0] c_rdata,
    output logic          c_stall,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic          l_err,
    output logic [DW-1:0] l_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

    localparam int unsigned LW = AW + 1;
    localparam logic [AW:0] AddrLimit = LW'(DEPTH_WORDS * 4);

    state_e        state;
    logic          grant_l;  // loader owns the access in flight
    logic          last_l;   // loader received the most recent grant
    logic          lat_we;
    logic [2:0]    cnt;

    logic          pick_l;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_bad;

    always_comb begin
        pick_l = l_req;
        if (c_req && l_req) begin
            pick_l = ~last_l;
        end
        sel_we    = pick_l ? l_we    : c_we;
        sel_addr  = pick_l ? l_addr  : c_addr;
        sel_wdata = pick_l ? l_wdata : c_wdata;
        sel_bad   = (sel_addr[1:0] != 2'b00) || ({1'b0, sel_addr} >= AddrLimit);
    end

    assign c_stall = c_req & ~c_ack;

    // Acks are registered one cycle early so they are high exactly while in RESP.
    always_ff @(posedge clk) begin
        if (!areset) begin
            state     <= StIdle;
            grant_l   <= 1'b0;
            last_l    <= 1'b1;
            lat_we    <= 1'b0;
            cnt       <= 3'd0;
            c_ack     <= 1'b0;
            c_err     <= 1'b0;
            c_rdata   <= '0;
            l_ack     <= 1'b0;
            l_err     <= 1'b0;
            l_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            c_ack     <= 1'b0;
            c_err     <= 1'b0;
            l_ack     <= 1'b0;
            l_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            unique case (state)
                StIdle: begin
                    if (c_req || l_req) begin
                        grant_l <= pick_l;
                        last_l  <= pick_l;
                        lat_we  <= sel_we;
                        if (sel_bad) begin
                            state <= StResp;
                            c_ack <= ~pick_l;
                            c_err <= ~pick_l;
                            l_ack <= pick_l;
                            l_err <= pick_l;
                        end else begin
                            state     <= StAccess;
                            mem_en    <= 1'b1;
                            mem_we    <= sel_we;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                StAccess: begin
                    if (lat_we) begin
                        state <= StResp;
                        c_ack <= ~grant_l;
                        l_ack <= grant_l;
                    end else begin
                        cnt   <= 3'(RD_LAT);
                        state <= StWait;
                    end
                end
                StWait: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        if (grant_l) begin
                            l_rdata <= mem_rdata;
                        end else begin
                            c_rdata <= mem_rdata;
                        end
                        c_ack <= ~grant_l;
                        l_ack <= grant_l;
                        state <= StResp;
                    end
                end
                StResp: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the core load/store path (port C) and a program/data loader (port L).
- Sequences each access through a small FSM, returns registered read data and a one-cycle acknowledge, and generates the core stall.
- Sits between the CU/ALU load-store path and the data memory, replacing the core's direct connection.

Parameters:
- AW, 32: address width (byte address).
- DW, 32: data width.
- RD_LAT, 1: data-memory read latency in cycles after the access cycle; legal range 1..4.
- DEPTH_WORDS, 64: number of words in the memory; used for the range check.

Ports:
- clk  in  1  system clock, rising edge
- areset  in  1  synchronous, active-low reset
- c_req  in  1  core request; level, held until c_ack
- c_we  in  1  core write enable; stable while c_req=1
- c_addr  in  AW  core byte address
- c_wdata  in  DW  core write data
- c_ack  out  1  one-cycle completion pulse for the core
- c_err  out  1  valid with c_ack; access rejected
- c_rdata  out  DW  core read data; valid with c_ack on reads
- c_stall  out  1  c_req & ~c_ack; holds the core PC
- l_req, l_we, l_addr, l_wdata  in  1/1/AW/DW  loader request group; same rules as the core group
- l_ack, l_err, l_rdata  out  1/1/DW  loader response group
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid RD_LAT cycles after the mem_en cycle

Behaviour:
- Reset: sampled on the clk rising edge while areset=0. Next state is IDLE, the wait counter clears, the rdata registers clear and last_grant=L, so C wins the first tie. All acks and errs go to 0 and mem_en/mem_we go to 0. mem_addr and mem_wdata are 0 in IDLE.
- Reset mid-operation: any in-flight access is abandoned and no ack is issued. A write whose ACCESS cycle already occurred stays committed.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not equal to last_grant, then update last_grant.
  - Latch the grant, we, addr and wdata, and go to ACCESS.
  - If neither req is high, stay in IDLE.
- Error check in IDLE: addr[1:0]!=0 or addr>=DEPTH_WORDS*4 sets the latched err flag. The FSM then goes directly to RESP, with no mem_en pulse.
- ACCESS (exactly one cycle):
  - mem_en=1, mem_we=latched we, and mem_addr/mem_wdata come from the latches.
  - A write goes to RESP.
  - A read loads counter=RD_LAT and goes to WAIT.
- WAIT:
  - The counter decrements each cycle.
  - In the cycle where counter==1, mem_rdata is captured into the granted port's rdata register and the FSM goes to RESP.
  - The non-granted port's rdata register holds its value.
- RESP (one cycle): the granted port's ack=1 and err=latched err. The other port's ack=0. Next state is IDLE.
- Latency from req sampled in IDLE (cycle 0) to ack:
  - Write: cycle 2.
  - Read: cycle 2+RD_LAT.
  - Error: cycle 1.
- Re-request: a req still high in the IDLE cycle after RESP is treated as a new request. Requesters drop req on the edge after seeing ack.
- Requests that arrive during ACCESS/WAIT/RESP are held by the requester and arbitrated at the next IDLE. Round-robin bounds a waiting port to at most one foreign access.
- On a write, c_rdata/l_rdata are unchanged.
- c_stall is combinational: 1 from c_req rise until the c_ack cycle inclusive-exclusive, i.e. 0 in the ack cycle.
- Violations: changing addr/we/wdata while req=1 has no effect once the request is latched, so the latched copy is used.

Test Plan:
- Core write alone: c_req=1, c_we=1, c_addr=0x10, c_wdata=0xDEADBEEF at cycle 0 -> mem_en=mem_we=1 with addr 0x10 at cycle 1; c_ack=1, c_err=0 at cycle 2; c_stall=1 in cycles 0-1.
- Core read, RD_LAT=1: the memory returns 0xDEADBEEF one cycle after mem_en -> c_ack at cycle 3 with c_rdata=0xDEADBEEF; repeat with RD_LAT=3 -> ack at cycle 5.
- Simultaneous requests after reset: both req at cycle 0 -> C is served first, then L. L is served at the next IDLE, with l_ack at cycle 5 for writes. With both held continuously, grants alternate C, L, C, L.
- Error: c_addr=0x102 -> c_ack=1, c_err=1 at cycle 1 with no mem_en. l_addr=0x100 with DEPTH_WORDS=64 -> l_err=1.
- Reset mid-read: areset=0 during WAIT -> next cycle IDLE, no ack, last_grant=L; a following core read completes normally.
- Loader preload then core fetch: the loader writes 0x11,0x22 to 0x0,0x4, then the core reads 0x4 -> c_rdata=0x22, l_rdata unchanged.
